// File: rtl/mc_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : mc_control_fsm
// Description : Multicycle MIPS control unit with memory-ready wait and abort.
//               Optional illegal-opcode trap enabled by MC_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_control_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int WCNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       mem_timeout,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP = 4'd12
`endif
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [WCNT_W-1:0] c_WAIT_MAX = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] c_WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic              w_waiting;
  logic              w_timeout;

  logic w_pcwrite, w_irwrite, w_regwrite, w_memwrite;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready;
  assign w_timeout = (WAIT_MAX != 0) && w_waiting && (r_wcnt == c_WAIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // A timeout re-enters FETCH from FETCH, so it must clear the counter explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if ((w_next != r_state) || w_timeout) begin
      r_wcnt <= '0;
    end else if (w_waiting) begin
      r_wcnt <= r_wcnt + c_WCNT_ONE;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memen      = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        memen   = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          memen  = 1'b0;
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memen = 1'b1;
        iord  = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          memen  = 1'b0;
          w_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        memen      = 1'b1;
        iord       = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          memen      = 1'b0;
          w_memwrite = 1'b0;
          w_next     = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        w_next  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_next = S_TRAP;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset overrides the decoded enables so no write escapes while rst is high.
  assign pcwrite     = w_pcwrite  & ~rst;
  assign irwrite     = w_irwrite  & ~rst;
  assign regwrite    = w_regwrite & ~rst;
  assign memwrite    = w_memwrite & ~rst;
  assign mem_timeout = w_timeout  & ~rst;
  assign state       = r_state;

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (r_state == S_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_op = r_illegal | (r_state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm (honours MC_ILLEGAL_TRAP_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, branch, iord, memen, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, mem_timeout, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  mc_control_fsm #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memen(memen),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .mem_timeout(mem_timeout), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Control word layout, MSB first.
  localparam logic [17:0] PCW = 18'(1) << 17, BR = 18'(1) << 16, IORD = 18'(1) << 15;
  localparam logic [17:0] MEM = 18'(1) << 14, MW = 18'(1) << 13, IRW = 18'(1) << 12;
  localparam logic [17:0] RDST = 18'(1) << 11, M2R = 18'(1) << 10, RW = 18'(1) << 9;
  localparam logic [17:0] ASA = 18'(1) << 8, B01 = 18'(1) << 6, B10 = 18'(2) << 6;
  localparam logic [17:0] B11 = 18'(3) << 6, PC01 = 18'(1) << 4, PC10 = 18'(2) << 4;
  localparam logic [17:0] AO01 = 18'(1) << 2, AO10 = 18'(2) << 2, TMO = 18'(2), ILL = 18'(1);

  localparam logic [17:0] E_RST   = MEM | B01;
  localparam logic [17:0] E_FW    = MEM | B01;
  localparam logic [17:0] E_FR    = MEM | B01 | IRW | PCW;
  localparam logic [17:0] E_FTMO  = B01 | TMO;
  localparam logic [17:0] E_DEC   = B11;
  localparam logic [17:0] E_MADR  = ASA | B10;
  localparam logic [17:0] E_MRD   = MEM | IORD;
  localparam logic [17:0] E_MRTMO = IORD | TMO;
  localparam logic [17:0] E_MWB   = RW | M2R;
  localparam logic [17:0] E_MWR   = MEM | IORD | MW;
  localparam logic [17:0] E_EXEC  = ASA | AO10;
  localparam logic [17:0] E_ALUWB = RW | RDST;
  localparam logic [17:0] E_BR    = ASA | AO01 | PC01 | BR;
  localparam logic [17:0] E_AIEX  = ASA | B10;
  localparam logic [17:0] E_AIWB  = RW;
  localparam logic [17:0] E_JUMP  = PC10 | PCW;
  localparam logic [17:0] E_TRAP  = ILL;

  logic [17:0] act;
  assign act = {pcwrite, branch, iord, memen, memwrite, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, pcsrc, aluop, mem_timeout, illegal_op};

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [17:0] cw;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Inputs change on the falling edge; the monitor samples 1 time unit later.
  task automatic step(input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] s, input logic [17:0] c, input string nm);
    @(negedge clk);
    rst       = r;
    op        = o;
    mem_ready = m;
    q.push_back('{name: nm, st: s, cw: c});
  endtask

  always @(negedge clk) begin
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (state !== e.st || act !== e.cw) begin
        n_fail++;
        $display("FAIL %s: got state=%0d cw=%h, expected state=%0d cw=%h",
                 e.name, state, act, e.st, e.cw);
      end
    end
  end

  initial begin
    step(1, 6'h00, 1, 0, E_RST, "reset_a");
    step(1, 6'h00, 1, 0, E_RST, "reset_b");

    // R-type
    step(0, 6'h00, 1, 0,  E_FR,    "r_fetch");
    step(0, 6'h00, 1, 1,  E_DEC,   "r_decode");
    step(0, 6'h00, 1, 6,  E_EXEC,  "r_exec");
    step(0, 6'h00, 1, 7,  E_ALUWB, "r_aluwb");

    // LW with three wait cycles in MEMRD
    step(0, 6'h23, 1, 0, E_FR,   "lw_fetch");
    step(0, 6'h23, 1, 1, E_DEC,  "lw_decode");
    step(0, 6'h23, 1, 2, E_MADR, "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, 6'h23, 0, 3, E_MRD, "lw_memrd_wait");
    step(0, 6'h23, 1, 3, E_MRD,  "lw_memrd_done");
    step(0, 6'h23, 1, 4, E_MWB,  "lw_memwb");

    // SW
    step(0, 6'h2b, 1, 0, E_FR,   "sw_fetch");
    step(0, 6'h2b, 1, 1, E_DEC,  "sw_decode");
    step(0, 6'h2b, 1, 2, E_MADR, "sw_memadr");
    step(0, 6'h2b, 1, 5, E_MWR,  "sw_memwr");

    // BEQ then J
    step(0, 6'h04, 1, 0,  E_FR,   "beq_fetch");
    step(0, 6'h04, 1, 1,  E_DEC,  "beq_decode");
    step(0, 6'h04, 1, 8,  E_BR,   "beq_branch");
    step(0, 6'h02, 1, 0,  E_FR,   "j_fetch");
    step(0, 6'h02, 1, 1,  E_DEC,  "j_decode");
    step(0, 6'h02, 1, 11, E_JUMP, "j_jump");

    // ADDI
    step(0, 6'h08, 1, 0,  E_FR,   "addi_fetch");
    step(0, 6'h08, 1, 1,  E_DEC,  "addi_decode");
    step(0, 6'h08, 1, 9,  E_AIEX, "addi_ex");
    step(0, 6'h08, 1, 10, E_AIWB, "addi_wb");

    // FETCH timeout twice, then asynchronous reset mid-wait
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 15; i++) step(0, 6'h00, 0, 0, E_FW, "fetch_wait");
      step(0, 6'h00, 0, 0, E_FTMO, "fetch_timeout");
    end
    for (int i = 0; i < 5; i++) step(0, 6'h00, 0, 0, E_FW, "fetch_wait_pre_rst");
    step(1, 6'h00, 0, 0, E_RST, "rst_midwait_a");
    step(1, 6'h00, 1, 0, E_RST, "rst_midwait_b");

    // mem_ready on the last allowed wait cycle wins over timeout
    for (int i = 0; i < 15; i++) step(0, 6'h00, 0, 0, E_FW, "rdy_wins_wait");
    step(0, 6'h00, 1, 0, E_FR,    "rdy_wins_fetch");
    step(0, 6'h00, 1, 1, E_DEC,   "rdy_wins_decode");
    step(0, 6'h00, 1, 6, E_EXEC,  "rdy_wins_exec");
    step(0, 6'h00, 1, 7, E_ALUWB, "rdy_wins_aluwb");

    // MEMRD timeout
    step(0, 6'h23, 1, 0, E_FR,   "lwto_fetch");
    step(0, 6'h23, 1, 1, E_DEC,  "lwto_decode");
    step(0, 6'h23, 1, 2, E_MADR, "lwto_memadr");
    for (int i = 0; i < 15; i++) step(0, 6'h23, 0, 3, E_MRD, "lwto_wait");
    step(0, 6'h23, 0, 3, E_MRTMO, "lwto_timeout");

    // SW with two wait cycles
    step(0, 6'h2b, 1, 0, E_FR,   "sww_fetch");
    step(0, 6'h2b, 1, 1, E_DEC,  "sww_decode");
    step(0, 6'h2b, 1, 2, E_MADR, "sww_memadr");
    step(0, 6'h2b, 0, 5, E_MWR,  "sww_wait_a");
    step(0, 6'h2b, 0, 5, E_MWR,  "sww_wait_b");
    step(0, 6'h2b, 1, 5, E_MWR,  "sww_done");

    // Unknown opcode
    step(0, 6'h3f, 1, 0, E_FR,  "ill_fetch");
    step(0, 6'h3f, 1, 1, E_DEC, "ill_decode");
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) step(0, 6'h3f, i[0], 12, E_TRAP, "ill_trap");
    step(1, 6'h00, 1, 0, E_RST, "ill_rst");
`endif
    step(0, 6'h00, 1, 0, E_FR,  "post_ill_fetch");
    step(0, 6'h00, 1, 1, E_DEC, "post_ill_decode");

    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
